// File: rtl/wb_spi_flash_if.sv
// rtl/wb_spi_flash_if.sv - Wishbone read port bundle for wb_spi_flash
interface wb_spi_flash_if #(
  parameter int ADRW = 24
);
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [ADRW-1:0] adr_i;
  logic [31:0]     dat_o;
  logic            ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wb_spi_flash.sv
// rtl/wb_spi_flash.sv - read-only Wishbone responder fetching words from SPI NOR flash (READ 0x03, mode 0)
module wb_spi_flash #(
  parameter int CLKDIV = 1,
  parameter int ADRW   = 24
) (
  input  logic          clk_i,
  input  logic          rst_in,
  wb_spi_flash_if.slave wb,
  output logic          spi_cs_n_o,
  output logic          spi_sck_o,
  output logic          spi_mosi_o,
  input  logic          spi_miso_i
);
  // Divider counter doubles as the deselect-gap counter, so it must reach 2*CLKDIV.
  localparam int            CW       = $clog2(2 * CLKDIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLKDIV - 1);
  localparam logic [7:0]    CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_ACK,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_q;
  logic [5:0]    bit_q;
  logic          start_q;
  logic [31:0]   tx_q;
  logic [31:0]   rx_q;
  logic [31:0]   dat_q;
  logic          ack_q;
  logic          cs_n_q;
  logic          sck_q;
  logic          mosi_q;

  logic active;
  logic req;
  logic rd_req;
  logic wr_req;
  logic abort;
  logic tick;
  logic bit_end;
  logic last_bit;
  logic unused_adr;

  // Byte-lane bits of the address never reach the flash; word reads only.
  assign unused_adr = ^wb.adr_i[1:0];

  assign active   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  // A pending ack blocks re-acceptance of the same still-asserted write strobe.
  assign req      = (state_q == S_IDLE) && wb.cyc_i && wb.stb_i && !ack_q;
  assign rd_req   = req && !wb.we_i;
  assign wr_req   = req && wb.we_i;
  assign abort    = active && !wb.cyc_i;
  assign tick     = (div_q == DIV_LAST);
  // A bit finishes when its high phase expires; the start cycle has no bit yet.
  assign bit_end  = active && !start_q && tick && sck_q;
  assign last_bit = (bit_q == 6'd63);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: phase boundaries follow the bit counter, abort wins over everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_req) state_d = S_CMD;
      end
      S_CMD: begin
        if (abort)                       state_d = S_GAP;
        else if (bit_end && bit_q == 6'd7) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (abort)                        state_d = S_GAP;
        else if (bit_end && bit_q == 6'd31) state_d = S_DATA;
      end
      S_DATA: begin
        if (abort)                 state_d = S_GAP;
        else if (bit_end && last_bit) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        if (div_q == GAP_LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Serial engine: drives SCK/MOSI/CS, shifts MISO in, and produces the registered bus response.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      div_q   <= '0;
      bit_q   <= '0;
      start_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (wr_req) begin
        ack_q <= 1'b1;
      end else if (rd_req) begin
        tx_q    <= {CMD_READ, wb.adr_i[23:2], 2'b00};
        div_q   <= '0;
        bit_q   <= '0;
        start_q <= 1'b1;
      end else if (abort) begin
        cs_n_q  <= 1'b1;
        sck_q   <= 1'b0;
        mosi_q  <= 1'b0;
        start_q <= 1'b0;
        div_q   <= '0;
      end else if (active) begin
        if (start_q) begin
          // Select the flash and present the first command bit for the first low phase.
          cs_n_q  <= 1'b0;
          mosi_q  <= tx_q[31];
          start_q <= 1'b0;
        end else if (!tick) begin
          div_q <= div_q + CW'(1);
        end else begin
          div_q <= '0;
          if (!sck_q) begin
            sck_q <= 1'b1;
            if (state_q == S_DATA) rx_q <= {rx_q[30:0], spi_miso_i};
          end else begin
            sck_q <= 1'b0;
            if (last_bit) begin
              cs_n_q <= 1'b1;
              mosi_q <= 1'b0;
              ack_q  <= 1'b1;
              // First byte off the wire lands in the least significant lane.
              dat_q  <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end else begin
              bit_q  <= bit_q + 6'd1;
              // Zeros shift in behind the address, so MOSI rests low through DATA.
              mosi_q <= tx_q[30];
              tx_q   <= {tx_q[30:0], 1'b0};
            end
          end
        end
      end else if (state_q == S_GAP) begin
        div_q <= div_q + CW'(1);
      end
    end
  end

  assign wb.dat_o   = dat_q;
  assign wb.ack_o   = ack_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;
endmodule
